fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline, directly upstream of the control unit. It holds the program counter and drives the instruction-memory address. It registers each fetched instruction with its PC+4 into IF/ID; the opcode field of the registered instruction feeds the control decoder. It also resolves next-PC selection (sequential, ID-stage jump, EX-stage branch) and performs stalls and flushes.

---
 rtl/mips_defs.sv | 24 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/if_id_register.sv | 38 +++
 rtl/fetch_stage.sv | 70 +++++++
 tb/tb_fetch_stage.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/mips_defs.sv
// Shared MIPS definitions used by the fetch, control and hazard units.
package mips_defs;

    localparam logic [31:0] MIPS_RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] MIPS_NOP_INSTR = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int JIDX_MSB   = 25;
    localparam int JIDX_LSB   = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcPlus4;
        logic        valid;
    } if_id_t;

    // J-type target: upper nibble of PC+4, word index, word-aligned.
    function automatic logic [31:0] jumpTarget(input logic [3:0]  pcHi,
                                               input logic [25:0] jIdx);
        return {pcHi, jIdx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its hazard/control/EX/imem neighbours.
interface fetch_stage_if;

    logic        Stall;
    logic        Jump;
    logic        BranchEQ_EX;
    logic        BranchNE_EX;
    logic        Zero_EX;
    logic [31:0] BranchTarget_EX;
    logic [31:0] Instruction;
    logic [31:0] InstrAddr;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        FlushEX;

    modport master (
        input  Stall, Jump, BranchEQ_EX, BranchNE_EX, Zero_EX, BranchTarget_EX, Instruction,
        output InstrAddr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, FlushEX
    );

    modport slave (
        output Stall, Jump, BranchEQ_EX, BranchNE_EX, Zero_EX, BranchTarget_EX, Instruction,
        input  InstrAddr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, FlushEX
    );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register; flush beats hold beats load.
module if_id_register import mips_defs::*; #(
    parameter logic [31:0] NOP_INSTR = MIPS_NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush_i,
    input  logic   hold_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t bubble;
    if_id_t ifId_q;
    if_id_t ifId_d;

    assign bubble = '{instr: NOP_INSTR, pcPlus4: 32'h0, valid: 1'b0};

    always_comb begin
        ifId_d = d_i;
        if (flush_i) begin
            ifId_d = bubble;
        end else if (hold_i) begin
            ifId_d = ifId_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifId_q <= bubble;
        end else begin
            ifId_q <= ifId_d;
        end
    end

    assign q_o = ifId_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, stall/flush control and IF/ID.
module fetch_stage import mips_defs::*; #(
    parameter logic [31:0] RESET_PC  = MIPS_RESET_PC,
    parameter logic [31:0] NOP_INSTR = MIPS_NOP_INSTR
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pcPlus4;
    logic        branchTaken;
    logic        jumpTaken;
    logic        flushIfId;
    logic        holdIfId;
    if_id_t      ifIdIn;
    if_id_t      ifIdOut;

    assign pcPlus4     = pc_q + 32'd4;
    assign branchTaken = (bus.BranchEQ_EX & bus.Zero_EX) | (bus.BranchNE_EX & ~bus.Zero_EX);
    assign jumpTaken   = bus.Jump & ifIdOut.valid & ~bus.Stall;

    // A taken branch is older than anything in IF/ID, so it overrides both a jump and a stall.
    always_comb begin
        pc_d      = pc_q;
        flushIfId = 1'b0;
        holdIfId  = 1'b0;
        if (branchTaken) begin
            pc_d      = bus.BranchTarget_EX;
            flushIfId = 1'b1;
        end else if (jumpTaken) begin
            pc_d      = jumpTarget(ifIdOut.pcPlus4[31:28], ifIdOut.instr[JIDX_MSB:JIDX_LSB]);
            flushIfId = 1'b1;
        end else if (bus.Stall) begin
            holdIfId  = 1'b1;
        end else begin
            pc_d      = pcPlus4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign ifIdIn = '{instr: bus.Instruction, pcPlus4: pcPlus4, valid: 1'b1};

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifId (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flushIfId),
        .hold_i  (holdIfId),
        .d_i     (ifIdIn),
        .q_o     (ifIdOut)
    );

    assign bus.InstrAddr         = pc_q;
    assign bus.IF_ID_Instruction = ifIdOut.instr;
    assign bus.IF_ID_PCPlus4     = ifIdOut.pcPlus4;
    assign bus.IF_ID_Valid       = ifIdOut.valid;
    assign bus.FlushEX           = branchTaken;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: stimulus pushes expected state, a negedge monitor checks it.
module tb_fetch_stage;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        flush;
    } exp_t;

    logic clk;
    logic rstN;
    int   checks;
    int   errors;
    exp_t expQ[$];
    exp_t cur;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk   (clk),
        .reset (rstN),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small instruction memory: one J instruction at 0x0040_0004, address-tagged words elsewhere.
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0040_0004) return 32'h0810_0010;
        return {16'h2000, a[15:0]};
    endfunction

    assign bus.Instruction = imem(bus.InstrAddr);

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s got=%h expected=%h", name, field, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            cur = expQ.pop_front();
            checkOutput(cur.name, "InstrAddr", bus.InstrAddr, cur.addr);
            checkOutput(cur.name, "IF_ID_Instruction", bus.IF_ID_Instruction, cur.instr);
            checkOutput(cur.name, "IF_ID_PCPlus4", bus.IF_ID_PCPlus4, cur.pc4);
            checkOutput(cur.name, "IF_ID_Valid", {31'b0, bus.IF_ID_Valid}, {31'b0, cur.valid});
            checkOutput(cur.name, "FlushEX", {31'b0, bus.FlushEX}, {31'b0, cur.flush});
        end
    end

    task automatic applyStimulus(input logic stall, input logic jump, input logic beq,
                                 input logic bne, input logic zero, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        bus.Stall           = stall;
        bus.Jump            = jump;
        bus.BranchEQ_EX     = beq;
        bus.BranchNE_EX     = bne;
        bus.Zero_EX         = zero;
        bus.BranchTarget_EX = tgt;
    endtask

    task automatic expectState(input string name, input logic [31:0] addr, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic valid, input logic flush);
        exp_t e;
        e.name  = name;
        e.addr  = addr;
        e.instr = instr;
        e.pc4   = pc4;
        e.valid = valid;
        e.flush = flush;
        expQ.push_back(e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstN   = 1'b0;
        bus.Stall = 1'b0; bus.Jump = 1'b0; bus.BranchEQ_EX = 1'b0;
        bus.BranchNE_EX = 1'b0; bus.Zero_EX = 1'b0; bus.BranchTarget_EX = 32'h0;

        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectState("reset", 32'h0040_0000, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0); rstN = 1'b1;
        expectState("release", 32'h0040_0000, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectState("seq1", 32'h0040_0004, 32'h2000_0000, 32'h0040_0004, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectState("seq2", 32'h0040_0008, 32'h0810_0010, 32'h0040_0008, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectState("seq3", 32'h0040_000C, 32'h2000_0008, 32'h0040_000C, 1, 0);

        applyStimulus(0, 0, 0, 0, 0, 32'h0); rstN = 1'b0;
        expectState("rereset", 32'h0040_0000, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0); rstN = 1'b1;
        expectState("rerelease", 32'h0040_0000, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectState("jseq1", 32'h0040_0004, 32'h2000_0000, 32'h0040_0004, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        expectState("jumpSetup", 32'h0040_0008, 32'h0810_0010, 32'h0040_0008, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        expectState("jumpTaken", 32'h0040_0040, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 32'h0040_0100);
        expectState("jumpBubbleIgnored", 32'h0040_0044, 32'h2000_0040, 32'h0040_0044, 1, 1);
        applyStimulus(0, 0, 0, 1, 1, 32'h0040_0100);
        expectState("bneTaken", 32'h0040_0100, 32'h0, 32'h0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        expectState("bneNotTaken", 32'h0040_0104, 32'h2000_0100, 32'h0040_0104, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        expectState("stall1", 32'h0040_0104, 32'h2000_0100, 32'h0040_0104, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectState("stall2", 32'h0040_0104, 32'h2000_0100, 32'h0040_0104, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 32'h0);
        expectState("stallRelease", 32'h0040_0108, 32'h2000_0104, 32'h0040_0108, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        expectState("stallBlocksJump", 32'h0040_0108, 32'h2000_0104, 32'h0040_0108, 1, 0);
        applyStimulus(1, 0, 1, 0, 1, 32'h0040_0200);
        expectState("jumpAfterStall", 32'h0000_0410, 32'h0, 32'h0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectState("branchOverStall", 32'h0040_0200, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 32'h0040_0300);
        expectState("seqAfterBranch", 32'h0040_0204, 32'h2000_0200, 32'h0040_0204, 1, 1);
        applyStimulus(0, 0, 1, 0, 1, 32'hFFFF_FFFC);
        expectState("branchOverJump", 32'h0040_0300, 32'h0, 32'h0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectState("toTop", 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        expectState("wrap", 32'h0000_0000, 32'h2000_FFFC, 32'h0000_0000, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        expectState("wrapStall", 32'h0000_0000, 32'h2000_FFFC, 32'h0000_0000, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h0); rstN = 1'b0;
        expectState("asyncReset", 32'h0040_0000, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0); rstN = 1'b1;
        expectState("release2", 32'h0040_0000, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectState("seqAgain", 32'h0040_0004, 32'h2000_0000, 32'h0040_0004, 1, 0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        #1;
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
